// File: rtl/vga_plot_arbiter.sv
// ============================================================================
// vga_plot_arbiter
// ----------------------------------------------------------------------------
// Shares the single pixel-plot port between N_REQ drawing engines (screen
// clear, maze renderer, sprite renderer, ...). Requests are served in strict
// round-robin order. Each granted pixel produces a one-cycle ack to its
// requester. In-range pixels also produce a one-cycle plot strobe, followed
// by PLOT_GAP forced idle cycles. Out-of-range pixels are acked and dropped
// without a gap.
//
// Parameters:
//   N_REQ     number of requesters (2..8)
//   H_RES     visible width;  x >= H_RES is dropped
//   V_RES     visible height; y >= V_RES is dropped
//   PLOT_GAP  idle cycles after each issued plot (0..15)
//
// Ports:
//   CLOCK_50   in   system clock
//   reset      in   synchronous, active-high reset
//   req        in   [N_REQ]     per-requester level request
//   req_x      in   [N_REQ*10]  packed x, requester i at [10i+9:10i]
//   req_y      in   [N_REQ*9]   packed y, requester i at [9i+8:9i]
//   req_color  in   [N_REQ*24]  packed RGB888, requester i at [24i+23:24i]
//   ack        out  [N_REQ]     one-hot pulse, request i consumed
//   plot       out  1           one-cycle write strobe
//   VGA_X      out  10          registered pixel x
//   VGA_Y      out  9           registered pixel y
//   VGA_COLOR  out  24          registered pixel colour
//   busy       out  1           high while issuing or in the gap
//
// Optional feature (macro VGA_PLOT_ARB_STATS_EN):
//   drop_count out 16  out-of-range pixels acked, saturating
//   plot_count out 24  plot pulses issued, wrapping
// ============================================================================
module vga_plot_arbiter #(
    parameter int N_REQ    = 3,
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int PLOT_GAP = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*10-1:0] req_x,
    input  logic [N_REQ*9-1:0]  req_y,
    input  logic [N_REQ*24-1:0] req_color,
    output logic [N_REQ-1:0]    ack,
    output logic                plot,
    output logic [9:0]          VGA_X,
    output logic [8:0]          VGA_Y,
    output logic [23:0]         VGA_COLOR,
    output logic                busy
`ifdef VGA_PLOT_ARB_STATS_EN
    ,
    output logic [15:0]         drop_count,
    output logic [23:0]         plot_count
`endif
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [3:0]      gap_cnt;
    logic            cap_ok;      // pixel currently in ISSUE was in range

    // Round-robin search: first set request strictly after last_grant.
    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [9:0]      win_x;
    logic [8:0]      win_y;
    logic [23:0]     win_color;
    logic            win_in_range;
    int              cand;

    // NOTE: every variable written here gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant;
        cand      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= N_REQ)
                cand = cand - N_REQ;
            if (!win_found && req[cand[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
        win_x        = req_x[int'(win_idx)*10 +: 10];
        win_y        = req_y[int'(win_idx)*9 +: 9];
        win_color    = req_color[int'(win_idx)*24 +: 24];
        win_in_range = (int'(win_x) < H_RES) && (int'(win_y) < V_RES);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GW'(N_REQ - 1);
            gap_cnt    <= '0;
            cap_ok     <= 1'b0;
            ack        <= '0;
            plot       <= 1'b0;
            VGA_X      <= '0;
            VGA_Y      <= '0;
            VGA_COLOR  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        ack        <= N_REQ'(1) << win_idx;
                        last_grant <= win_idx;
                        cap_ok     <= win_in_range;
                        // Pixel registers change only together with a plot
                        // pulse, so a dropped pixel leaves them untouched.
                        if (win_in_range) begin
                            plot      <= 1'b1;
                            VGA_X     <= win_x;
                            VGA_Y     <= win_y;
                            VGA_COLOR <= win_color;
                        end
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end

                ISSUE: begin
                    ack  <= '0;
                    plot <= 1'b0;
                    if (cap_ok && (PLOT_GAP > 0)) begin
                        state   <= GAP;
                        gap_cnt <= 4'(PLOT_GAP);
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                GAP: begin
                    // Gap lasts exactly PLOT_GAP cycles: leave on the cycle
                    // the counter shows 1.
                    if (gap_cnt <= 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    ack   <= '0;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_PLOT_ARB_STATS_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            drop_count <= '0;
            plot_count <= '0;
        end else if (state == ISSUE) begin
            if (cap_ok)
                plot_count <= plot_count + 24'd1;
            else if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// ============================================================================
// tb_vga_plot_arbiter
// ----------------------------------------------------------------------------
// Bench for vga_plot_arbiter. Main instance uses PLOT_GAP=2 with three
// requester drivers that hold a pixel until acked; a second instance with
// PLOT_GAP=0 exercises back-to-back plotting. Expected grants are queued as
// stimulus is issued and consumed by a monitor whenever ack/plot appears.
// Optional-feature ports are connected when VGA_PLOT_ARB_STATS_EN is defined.
// ============================================================================
module tb_vga_plot_arbiter;

    localparam int N = 3;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [23:0] c;
    } pix_t;

    typedef struct {
        int          idx;
        logic        plot;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [23:0] c;
    } exp_t;

    logic           CLOCK_50 = 1'b0;
    logic           reset    = 1'b1;

    // Main instance (PLOT_GAP = 2)
    logic [N-1:0]    req = '0;
    logic [N*10-1:0] req_x = '0;
    logic [N*9-1:0]  req_y = '0;
    logic [N*24-1:0] req_color = '0;
    logic [N-1:0]    ack;
    logic            plot;
    logic [9:0]      VGA_X;
    logic [8:0]      VGA_Y;
    logic [23:0]     VGA_COLOR;
    logic            busy;

    // Second instance (PLOT_GAP = 0)
    logic [N-1:0]    d0_req = '0;
    logic [N*10-1:0] d0_x = '0;
    logic [N*9-1:0]  d0_y = '0;
    logic [N*24-1:0] d0_color = '0;
    logic [N-1:0]    d0_ack;
    logic            d0_plot;
    logic [9:0]      d0_VGA_X;
    logic [8:0]      d0_VGA_Y;
    logic [23:0]     d0_VGA_COLOR;
    logic            d0_busy;

`ifdef VGA_PLOT_ARB_STATS_EN
    logic [15:0] drop_count, d0_drop_count;
    logic [23:0] plot_count, d0_plot_count;
`endif

    vga_plot_arbiter #(.N_REQ(N), .H_RES(640), .V_RES(480), .PLOT_GAP(2)) u_dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .ack       (ack),
        .plot      (plot),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .busy      (busy)
`ifdef VGA_PLOT_ARB_STATS_EN
        , .drop_count(drop_count), .plot_count(plot_count)
`endif
    );

    vga_plot_arbiter #(.N_REQ(N), .H_RES(640), .V_RES(480), .PLOT_GAP(0)) u_dut0 (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .req       (d0_req),
        .req_x     (d0_x),
        .req_y     (d0_y),
        .req_color (d0_color),
        .ack       (d0_ack),
        .plot      (d0_plot),
        .VGA_X     (d0_VGA_X),
        .VGA_Y     (d0_VGA_Y),
        .VGA_COLOR (d0_VGA_COLOR),
        .busy      (d0_busy)
`ifdef VGA_PLOT_ARB_STATS_EN
        , .drop_count(d0_drop_count), .plot_count(d0_plot_count)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    exp_t        sb_q[$];
    logic        sb_en = 1'b0;
    logic [9:0]  mx = '0;
    logic [8:0]  my = '0;
    logic [23:0] mc = '0;

    // Expected response for a pixel granted to requester idx, in grant order.
    task automatic push_exp(input int idx, input logic [9:0] x, input logic [8:0] y, input logic [23:0] c);
        exp_t e;
        e.idx  = idx;
        e.plot = (x < 10'd640) && (y < 9'd480);
        if (e.plot) begin
            mx = x; my = y; mc = c;
        end
        e.x = mx; e.y = my; e.c = mc;
        sb_q.push_back(e);
    endtask

    // ---------------- requester drivers (main instance) ----------------
    pix_t         src_q[N][$];
    logic [N-1:0] ack_seen = '0;
    logic         flush = 1'b1;
    int           pres_q[$];
    pix_t         drv_p;

    always @(negedge CLOCK_50) ack_seen = ack;

    always @(posedge CLOCK_50) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (flush) begin
                req[i] = 1'b0;
                src_q[i].delete();
            end else begin
                if (ack_seen[i])
                    req[i] = 1'b0;
                if (!req[i] && src_q[i].size() > 0) begin
                    drv_p = src_q[i].pop_front();
                    req_x[i*10 +: 10]     = drv_p.x;
                    req_y[i*9 +: 9]       = drv_p.y;
                    req_color[i*24 +: 24] = drv_p.c;
                    req[i] = 1'b1;
                    pres_q.push_back(cyc);
                end
            end
        end
    end

    // ---------------- monitor (main instance) ----------------
    int   ack_cyc_q[$];
    int   plot_cyc_q[$];
    int   ack_cnt[N];
    int   last_plot_cyc = -1;
    exp_t mon_e;
    logic [N-1:0] mon_exp_ack;

    always @(negedge CLOCK_50) begin
        if (reset) begin
            last_plot_cyc = -1;
            for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        end else if (sb_en && (ack != '0 || plot)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_ack", 32'(ack), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                mon_exp_ack = N'(1) << mon_e.idx;
                check("sb_ack",   32'(ack),       32'(mon_exp_ack));
                check("sb_plot",  32'(plot),      32'(mon_e.plot));
                check("sb_x",     32'(VGA_X),     32'(mon_e.x));
                check("sb_y",     32'(VGA_Y),     32'(mon_e.y));
                check("sb_color", 32'(VGA_COLOR), 32'(mon_e.c));
            end
            for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
            ack_cyc_q.push_back(cyc);
            if (plot) begin
                if (last_plot_cyc >= 0)
                    check("plot_spacing_ge4", 32'((cyc - last_plot_cyc) >= 4), 32'd1);
                last_plot_cyc = cyc;
                plot_cyc_q.push_back(cyc);
            end
        end
    end

    // ---------------- monitor (gap-zero instance) ----------------
    int d0_plots = 0;
    int d0_first = 0;
    int d0_last  = 0;

    always @(negedge CLOCK_50) begin
        if (!reset && d0_plot) begin
            if (d0_plots == 0) d0_first = cyc;
            d0_last = cyc;
            d0_plots++;
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        flush = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_plot",  32'(plot),      32'd0);
        check("rst_ack",   32'(ack),       32'd0);
        check("rst_x",     32'(VGA_X),     32'd0);
        check("rst_y",     32'(VGA_Y),     32'd0);
        check("rst_color", 32'(VGA_COLOR), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        sb_q.delete();
        mx = '0; my = '0; mc = '0;
        reset = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            @(negedge CLOCK_50);
            t++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
        repeat (6) @(negedge CLOCK_50);
    endtask

    task automatic send(input int idx, input logic [9:0] x, input logic [8:0] y, input logic [23:0] c);
        pix_t p;
        p.x = x; p.y = y; p.c = c;
        src_q[idx].push_back(p);
        push_exp(idx, x, y, c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int got;
        do_reset();
        sb_en = 1'b1;

        // Single requester, two pixels: latency 1 and spacing 2+PLOT_GAP.
        ack_cyc_q.delete(); plot_cyc_q.delete(); pres_q.delete();
        @(negedge CLOCK_50);
        send(1, 10'd100, 9'd50, 24'h00FF00);
        send(1, 10'd101, 9'd51, 24'h0000FF);
        wait_drain("single_drain");
        if (ack_cyc_q.size() >= 1 && pres_q.size() >= 1)
            check("single_latency", 32'(ack_cyc_q[0] - pres_q[0]), 32'd1);
        else
            check("single_ack_seen", 32'(ack_cyc_q.size()), 32'd2);
        if (plot_cyc_q.size() >= 2)
            check("single_spacing", 32'(plot_cyc_q[1] - plot_cyc_q[0]), 32'd4);
        else
            check("single_plots", 32'(plot_cyc_q.size()), 32'd2);
        check("hold_x",    32'(VGA_X),     32'd101);
        check("hold_color", 32'(VGA_COLOR), 32'h0000FF);
        check("idle_busy", 32'(busy),      32'd0);

        // Reset during active traffic: outstanding pixels aborted, unchecked.
        sb_en = 1'b0;
        @(negedge CLOCK_50);
        for (int i = 0; i < N; i++) begin
            pix_t p;
            p.x = 10'(200 + i); p.y = 9'(20 + i); p.c = 24'(i + 1);
            src_q[i].push_back(p);
            src_q[i].push_back(p);
        end
        repeat (6) @(negedge CLOCK_50);
        do_reset();
        sb_en = 1'b1;

        // Fairness: all three held for 12 grants, starting at requester 0.
        @(negedge CLOCK_50);
        for (int k = 0; k < 12; k++)
            send(k % 3, 10'((k % 3) * 100 + k / 3), 9'((k % 3) * 10 + k / 3),
                 24'(((k % 3) << 16) | (k / 3)));
        wait_drain("fair_drain");
        for (int i = 0; i < N; i++)
            check($sformatf("fair_count%0d", i), 32'(ack_cnt[i]), 32'd4);

        // Out of range with a pending req[1]: dropped, no gap before req[1].
        ack_cyc_q.delete();
        @(negedge CLOCK_50);
        send(0, 10'd640, 9'd10, 24'hFF0000);
        send(1, 10'd5,   9'd6,  24'h112233);
        wait_drain("oor_drain");
        if (ack_cyc_q.size() >= 2)
            check("oor_no_gap", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd2);
        else
            check("oor_acks", 32'(ack_cyc_q.size()), 32'd2);
`ifdef VGA_PLOT_ARB_STATS_EN
        check("oor_drop_count", 32'(drop_count), 32'd1);
`endif

        // Boundaries: last visible pixel plotted, y=480 dropped.
        @(negedge CLOCK_50);
        send(2, 10'd639, 9'd479, 24'hABCDEF);
        send(0, 10'd0,   9'd480, 24'h123456);
        wait_drain("bound_drain");
        check("bound_hold_x", 32'(VGA_X), 32'd639);
        check("bound_hold_y", 32'(VGA_Y), 32'd479);

        // Gap zero: five pixels back to back on the PLOT_GAP=0 instance.
        for (int k = 0; k < 5; k++) begin
            @(posedge CLOCK_50);
            #1;
            d0_req[0] = 1'b1;
            d0_x[9:0] = 10'(k * 7);
            d0_y[8:0] = 9'(k + 1);
            d0_color[23:0] = 24'(k + 16);
            got = 0;
            for (int t = 0; t < 10 && got == 0; t++) begin
                @(negedge CLOCK_50);
                if (d0_ack[0]) got = 1;
            end
            check("gap0_ack",  32'(got),      32'd1);
            check("gap0_plot", 32'(d0_plot),  32'd1);
            check("gap0_x",    32'(d0_VGA_X), 32'(k * 7));
            check("gap0_y",    32'(d0_VGA_Y), 32'(k + 1));
        end
        @(posedge CLOCK_50);
        #1;
        d0_req = '0;
        repeat (5) @(negedge CLOCK_50);
        check("gap0_pulses", 32'(d0_plots), 32'd5);
        check("gap0_window", 32'(d0_last - d0_first), 32'd8);
`ifdef VGA_PLOT_ARB_STATS_EN
        check("gap0_plot_count", 32'(d0_plot_count), 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
